mem_bridge: RTL and testbench
=============================

Name: mem_bridge

Overview:
- Sits between the core's memory request port and a word-wide bus. The core's port carries a byte address, the RV32 funct3-encoded size, and write data.
- Converts each request into one or two word-aligned bus beats. Generates byte enables, merges read data and applies sign/zero extension.
- Hands the finished result back to the core's control FSM with a one-cycle response pulse.
- Lets the datapath issue LB/LH/LW/LBU/LHU/SB/SH/SW at any byte address.

Parameters:
- SPLIT_MISALIGNED, 1, 1: split misaligned accesses into two beats; 0: report a fault instead.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- req_valid  in  1  core request valid
- req_ready  out  1  bridge can accept a request
- req_we  in  1  1 = store
- req_addr  in  32  byte address
- req_size  in  3  mem_addr_t: 0 B, 1 H, 2 W, 4 BU, 5 HU
- req_wdata  in  32  store data, LSB-justified
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  extended load data (0 for stores and faults)
- rsp_fault  out  1  qualifies rsp_valid: illegal size or misaligned with split disabled
- bus_valid  out  1  bus request valid
- bus_ready  in  1  bus accepts the request
- bus_we  out  1  bus write
- bus_addr  out  32  word address, bits[1:0] = 0
- bus_be  out  4  byte enables
- bus_wdata  out  32  lane-aligned write data
- bus_rvalid  in  1  read data valid (bus is reset by the same rst)
- bus_rdata  in  32  read data

Behaviour:
- Reset:
  - rst is synchronous, active-high; clk is the clock.
  - Reset forces state IDLE and clears all outputs to 0 except req_ready, which is 1.
  - Reset mid-operation abandons the access immediately; bus_valid drops in the next cycle.
- States and handshake:
  - States: IDLE, BEAT0, WAIT0, BEAT1, WAIT1, RESP.
  - req_ready = (state == IDLE).
  - A request is accepted when req_valid && req_ready. The bridge latches addr, size, we, wdata and off = addr[1:0].
- Split condition:
  - split = (size H/HU && off == 3) || (size W && off != 0).
- Fault cases:
  - Illegal size (3, 6, 7), or split with SPLIT_MISALIGNED = 0, means IDLE → RESP with rsp_fault = 1 and no bus traffic.
- Lane computation:
  - mask = B: 0001, H: 0011, W: 1111.
  - be64 = mask << off.
  - wd64 = wdata << (8*off).
  - Beat 0: addr = {addr[31:2], 2'b00}, be = be64[3:0], wdata = wd64[31:0].
  - Beat 1: addr = beat-0 addr + 4, wrapping mod 2^32; be = be64[7:4], wdata = wd64[63:32].
- Bus beats:
  - In BEAT0/BEAT1, bus_valid = 1 and addr/be/wdata/we stay stable until bus_ready.
  - Store: after acceptance, go to BEAT1 if split, else RESP.
  - Load: after acceptance, go to WAIT0/WAIT1.
- Load data:
  - In WAIT0, bus_rvalid captures lo = bus_rdata, then go to BEAT1 if split, else RESP. In WAIT1, it captures hi, then go to RESP.
  - At most one beat is outstanding. bus_rvalid is never sampled in the cycle its beat is accepted and is ignored outside WAIT states.
  - Result: d = ({hi, lo} >> 8*off)[31:0], with hi = 0 when not split.
  - Extension: B sign-extends d[7], H sign-extends d[15], BU/HU zero-extend, W passes through.
- RESP:
  - rsp_valid = 1 for exactly one cycle, then IDLE. rsp_rdata and rsp_fault hold until the next response.
  - The response has no backpressure.
- Latency with zero wait states:
  - Aligned store: accept at T, bus_valid at T+1, rsp_valid at T+2.
  - Aligned load with rvalid one cycle after acceptance: rsp_valid at T+3.
  - A split access adds 1 cycle (store) or 2 cycles (load).
- Back-to-back: the earliest next accept is the cycle after RESP.
- Loads drive bus_be with the same enables as stores, as an informational hint.

Decomposition:
- Shared package (existing core package):
  - mem_addr_t size encoding.
  - New enum mbr_state_t.
  - Constants MEM_MASK_B/H/W.
- Sub-module mem_lane_align, combinational:
  - Store path: (size, off, wdata) → be64, wd64.
  - Load path: (size, off, hi, lo) → extended rdata.
  - Reused by the future I-cache fill path.
- The FSM stays in mem_bridge.

Test Plan:
- Aligned LW at 0x100, bus_rdata = 0xDEADBEEF → one beat, addr 0x100, be 1111; rsp_rdata = 0xDEADBEEF, fault 0, rsp_valid at T+3.
- LB at 0x203, word = 0x80FF_FF7F → be 1000, rsp_rdata = 0xFFFFFF80; LBU at the same address → 0x00000080.
- SW 0xAABBCCDD at 0x301 → beat 0: addr 0x300, be 1110, wdata 0xBBCCDDxx. Beat 1: addr 0x304, be 0001, wdata[7:0] = 0xAA.
- LW at 0xFFFFFFFE, words 0x1122_3344 @0xFFFFFFFC and 0x5566_7788 @0x0 → beat-1 addr wraps to 0x00000000; rsp_rdata = 0x77881122.
- req_size = 3, and with SPLIT_MISALIGNED = 0 a LH at 0x3 → no bus_valid ever; rsp_valid with rsp_fault = 1, rsp_rdata = 0.
- bus_ready held low 5 cycles during BEAT1 with rst asserted in cycle 3 → bus_valid low the following cycle, state IDLE, req_ready = 1, no rsp_valid.

Source files
------------

// File: rtl/mem_bridge_pkg.sv
// Shared memory-access definitions: funct3 size encoding, bridge states and byte masks.
package mem_bridge_pkg;

    typedef enum logic [2:0] {
        MEM_B  = 3'd0,
        MEM_H  = 3'd1,
        MEM_W  = 3'd2,
        MEM_BU = 3'd4,
        MEM_HU = 3'd5
    } mem_addr_t;

    typedef enum logic [2:0] {
        MBR_IDLE  = 3'd0,
        MBR_BEAT0 = 3'd1,
        MBR_WAIT0 = 3'd2,
        MBR_BEAT1 = 3'd3,
        MBR_WAIT1 = 3'd4,
        MBR_RESP  = 3'd5
    } mbr_state_t;

    localparam logic [3:0] MEM_MASK_B = 4'b0001;
    localparam logic [3:0] MEM_MASK_H = 4'b0011;
    localparam logic [3:0] MEM_MASK_W = 4'b1111;

    function automatic logic mem_size_legal(input logic [2:0] size);
        return (size == MEM_B) || (size == MEM_H) || (size == MEM_W) ||
               (size == MEM_BU) || (size == MEM_HU);
    endfunction

    // An access needs a second word when its bytes cross the word boundary.
    function automatic logic mem_is_split(input logic [2:0] size, input logic [1:0] off);
        return (((size == MEM_H) || (size == MEM_HU)) && (off == 2'd3)) ||
               ((size == MEM_W) && (off != 2'd0));
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: store enables/data into a two-word window,
// and load extraction plus sign/zero extension from that window.
module mem_lane_align
    import mem_bridge_pkg::*;
(
    input  logic [2:0]  size_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    output logic [7:0]  be64_o,
    output logic [63:0] wd64_o,
    output logic [31:0] rdata_o
);

    logic [3:0]  mask;
    logic [63:0] rd64;
    logic [31:0] d;

    always_comb begin
        mask = 4'b0000;
        case (size_i)
            MEM_B, MEM_BU: mask = MEM_MASK_B;
            MEM_H, MEM_HU: mask = MEM_MASK_H;
            MEM_W:         mask = MEM_MASK_W;
            default:       mask = 4'b0000;
        endcase
    end

    assign be64_o = {4'b0000, mask} << off_i;
    assign wd64_o = {32'h0, wdata_i} << {off_i, 3'b000};

    assign rd64 = {hi_i, lo_i} >> {off_i, 3'b000};
    assign d    = rd64[31:0];

    always_comb begin
        rdata_o = 32'h0;
        case (size_i)
            MEM_B:   rdata_o = {{24{d[7]}}, d[7:0]};
            MEM_H:   rdata_o = {{16{d[15]}}, d[15:0]};
            MEM_W:   rdata_o = d;
            MEM_BU:  rdata_o = {24'h0, d[7:0]};
            MEM_HU:  rdata_o = {16'h0, d[15:0]};
            default: rdata_o = 32'h0;
        endcase
    end

endmodule

// File: rtl/mem_bridge.sv
// Core memory port to word bus bridge: one or two aligned beats per request,
// with a single-cycle response pulse carrying extended load data or a fault.
//
// state | meaning
// IDLE  | ready for a core request
// BEAT0 | first (or only) bus beat offered
// WAIT0 | waiting for read data of beat 0
// BEAT1 | second beat of a split access offered
// WAIT1 | waiting for read data of beat 1
// RESP  | one-cycle response to the core
module mem_bridge
    import mem_bridge_pkg::*;
#(
    parameter bit SPLIT_MISALIGNED = 1'b1
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_size,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault,
    output logic        bus_valid,
    input  logic        bus_ready,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    mbr_state_t  state_q, state_d;
    logic [31:0] base_q, base_d;
    logic [2:0]  size_q, size_d;
    logic        we_q, we_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  off_q, off_d;
    logic        split_q, split_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_fault_q, rsp_fault_d;

    logic        accept;
    logic        req_split;
    logic        req_bad;
    logic [31:0] ld_hi;
    logic [31:0] ld_lo;
    logic [7:0]  be64;
    logic [63:0] wd64;
    logic [31:0] ld_data;

    assign accept    = req_valid && req_ready;
    assign req_split = mem_is_split(req_size, req_addr[1:0]);
    assign req_bad   = !mem_size_legal(req_size) || (req_split && !SPLIT_MISALIGNED);

    // Read data is fed straight from the bus in the capturing cycle so the
    // final result registers together with the transition into RESP.
    assign ld_lo = (state_q == MBR_WAIT0) ? bus_rdata : lo_q;
    assign ld_hi = (state_q == MBR_WAIT1) ? bus_rdata : 32'h0;

    mem_lane_align u_align (
        .size_i  (size_q),
        .off_i   (off_q),
        .wdata_i (wdata_q),
        .hi_i    (ld_hi),
        .lo_i    (ld_lo),
        .be64_o  (be64),
        .wd64_o  (wd64),
        .rdata_o (ld_data)
    );

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        size_d      = size_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        off_d       = off_q;
        split_d     = split_q;
        lo_d        = lo_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_fault_d = rsp_fault_q;
        case (state_q)
            MBR_IDLE: begin
                if (accept) begin
                    base_d  = {req_addr[31:2], 2'b00};
                    size_d  = req_size;
                    we_d    = req_we;
                    wdata_d = req_wdata;
                    off_d   = req_addr[1:0];
                    split_d = req_split;
                    lo_d    = 32'h0;
                    if (req_bad) begin
                        state_d     = MBR_RESP;
                        rsp_rdata_d = 32'h0;
                        rsp_fault_d = 1'b1;
                    end else begin
                        state_d = MBR_BEAT0;
                    end
                end
            end
            MBR_BEAT0: begin
                if (bus_ready) begin
                    if (!we_q) begin
                        state_d = MBR_WAIT0;
                    end else if (split_q) begin
                        state_d = MBR_BEAT1;
                    end else begin
                        state_d     = MBR_RESP;
                        rsp_rdata_d = 32'h0;
                        rsp_fault_d = 1'b0;
                    end
                end
            end
            MBR_WAIT0: begin
                if (bus_rvalid) begin
                    lo_d = bus_rdata;
                    if (split_q) begin
                        state_d = MBR_BEAT1;
                    end else begin
                        state_d     = MBR_RESP;
                        rsp_rdata_d = ld_data;
                        rsp_fault_d = 1'b0;
                    end
                end
            end
            MBR_BEAT1: begin
                if (bus_ready) begin
                    if (we_q) begin
                        state_d     = MBR_RESP;
                        rsp_rdata_d = 32'h0;
                        rsp_fault_d = 1'b0;
                    end else begin
                        state_d = MBR_WAIT1;
                    end
                end
            end
            MBR_WAIT1: begin
                if (bus_rvalid) begin
                    state_d     = MBR_RESP;
                    rsp_rdata_d = ld_data;
                    rsp_fault_d = 1'b0;
                end
            end
            MBR_RESP: state_d = MBR_IDLE;
            default:  state_d = MBR_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= MBR_IDLE;
            base_q      <= 32'h0;
            size_q      <= 3'd0;
            we_q        <= 1'b0;
            wdata_q     <= 32'h0;
            off_q       <= 2'd0;
            split_q     <= 1'b0;
            lo_q        <= 32'h0;
            rsp_rdata_q <= 32'h0;
            rsp_fault_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            size_q      <= size_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            off_q       <= off_d;
            split_q     <= split_d;
            lo_q        <= lo_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_fault_q <= rsp_fault_d;
        end
    end

    assign req_ready = (state_q == MBR_IDLE);
    assign rsp_valid = (state_q == MBR_RESP);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_fault = rsp_fault_q;

    // Bus fields are forced to zero outside beat states so idle/reset outputs are clean.
    assign bus_valid = (state_q == MBR_BEAT0) || (state_q == MBR_BEAT1);
    assign bus_we    = bus_valid && we_q;
    assign bus_addr  = (state_q == MBR_BEAT0) ? base_q :
                       (state_q == MBR_BEAT1) ? base_q + 32'd4 : 32'h0;
    assign bus_be    = (state_q == MBR_BEAT0) ? be64[3:0] :
                       (state_q == MBR_BEAT1) ? be64[7:4] : 4'b0000;
    assign bus_wdata = (state_q == MBR_BEAT0) ? wd64[31:0] :
                       (state_q == MBR_BEAT1) ? wd64[63:32] : 32'h0;

endmodule

// File: tb/tb_mem_bridge.sv
// Directed bench for mem_bridge: split and unsplit loads/stores, faults,
// bus stalls and a mid-access reset, with hand-computed expectations.
module tb_mem_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_valid_n;
    logic        req_we;
    logic [31:0] req_addr;
    logic [2:0]  req_size;
    logic [31:0] req_wdata;
    logic        bus_ready, bus_rvalid;
    logic [31:0] bus_rdata;

    logic        req_ready, rsp_valid, rsp_fault, bus_valid, bus_we;
    logic [31:0] rsp_rdata, bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        req_ready_n, rsp_valid_n, rsp_fault_n, bus_valid_n, bus_we_n;
    logic [31:0] rsp_rdata_n, bus_addr_n, bus_wdata_n;
    logic [3:0]  bus_be_n;

    logic        sel;
    logic        o_rsp_valid, o_rsp_fault, o_bus_valid, o_bus_we;
    logic [31:0] o_rsp_rdata, o_bus_addr, o_bus_wdata;
    logic [3:0]  o_bus_be;

    int tests = 0;
    int fails = 0;

    int          nbeats, nvalid, unstable, rsp_cyc;
    logic [31:0] b_addr [2];
    logic [3:0]  b_be   [2];
    logic [31:0] b_wd   [2];
    logic [31:0] r_rdata;
    logic        r_fault;

    always #5 clk = ~clk;

    mem_bridge #(.SPLIT_MISALIGNED(1'b1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault),
        .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    mem_bridge #(.SPLIT_MISALIGNED(1'b0)) dut_ns (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_n), .req_ready(req_ready_n), .req_we(req_we),
        .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid_n), .rsp_rdata(rsp_rdata_n), .rsp_fault(rsp_fault_n),
        .bus_valid(bus_valid_n), .bus_ready(bus_ready), .bus_we(bus_we_n),
        .bus_addr(bus_addr_n), .bus_be(bus_be_n), .bus_wdata(bus_wdata_n),
        .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    assign o_rsp_valid = sel ? rsp_valid_n : rsp_valid;
    assign o_rsp_fault = sel ? rsp_fault_n : rsp_fault;
    assign o_rsp_rdata = sel ? rsp_rdata_n : rsp_rdata;
    assign o_bus_valid = sel ? bus_valid_n : bus_valid;
    assign o_bus_we    = sel ? bus_we_n    : bus_we;
    assign o_bus_addr  = sel ? bus_addr_n  : bus_addr;
    assign o_bus_be    = sel ? bus_be_n    : bus_be;
    assign o_bus_wdata = sel ? bus_wdata_n : bus_wdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case ({a[31:2], 2'b00})
            32'h0000_0100: return 32'hDEAD_BEEF;
            32'h0000_0200: return 32'h80FF_FF7F;
            32'h0000_0204: return 32'h0000_00C3;
            32'hFFFF_FFFC: return 32'h1122_3344;
            32'h0000_0000: return 32'h5566_7788;
            default:       return 32'h0000_0000;
        endcase
    endfunction

    // Issue one request and play the bus for up to 40 cycles after acceptance.
    // stall0/stall1: cycles bus_ready stays low on beat 0 / beat 1.
    task automatic access(input logic s, input logic we, input logic [31:0] addr,
                          input logic [2:0] size, input logic [31:0] wd,
                          input int stall0, input int stall1);
        int          stall;
        int          lim;
        logic        pend;
        logic [31:0] pend_addr, p_addr, p_wd;
        logic [3:0]  p_be;
        logic        p_we;
        sel = s;
        @(negedge clk);
        if (s) req_valid_n = 1'b1;
        else   req_valid   = 1'b1;
        req_we = we; req_addr = addr; req_size = size; req_wdata = wd;
        bus_ready = 1'b0; bus_rvalid = 1'b0;
        @(negedge clk);
        req_valid = 1'b0; req_valid_n = 1'b0;
        nbeats = 0; nvalid = 0; unstable = 0; rsp_cyc = -1;
        stall = 0; pend = 1'b0; pend_addr = 32'h0;
        p_addr = 32'h0; p_wd = 32'h0; p_be = 4'h0; p_we = 1'b0;
        r_rdata = 32'h0; r_fault = 1'b0;
        for (int n = 1; n <= 40 && rsp_cyc < 0; n++) begin
            bus_rvalid = pend;
            bus_rdata  = pend ? mem_word(pend_addr) : 32'h0BAD_F00D;
            pend = 1'b0;
            if (o_rsp_valid) begin
                rsp_cyc = n; r_rdata = o_rsp_rdata; r_fault = o_rsp_fault;
            end
            if (o_bus_valid) begin
                nvalid++;
                if (stall > 0 && (o_bus_addr !== p_addr || o_bus_be !== p_be ||
                                  o_bus_wdata !== p_wd || o_bus_we !== p_we))
                    unstable++;
                p_addr = o_bus_addr; p_be = o_bus_be; p_wd = o_bus_wdata; p_we = o_bus_we;
                lim = (nbeats == 0) ? stall0 : stall1;
                if (stall >= lim) begin
                    bus_ready = 1'b1;
                    if (nbeats < 2) begin
                        b_addr[nbeats] = o_bus_addr;
                        b_be[nbeats]   = o_bus_be;
                        b_wd[nbeats]   = o_bus_wdata;
                    end
                    nbeats++;
                    if (!o_bus_we) begin
                        pend = 1'b1; pend_addr = o_bus_addr;
                    end
                    stall = 0;
                end else begin
                    bus_ready = 1'b0;
                    stall++;
                end
            end else begin
                bus_ready = 1'b0;
            end
            @(negedge clk);
        end
        bus_ready = 1'b0; bus_rvalid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rsp_seen;
        rst = 1'b1; sel = 1'b0;
        req_valid = 1'b0; req_valid_n = 1'b0; req_we = 1'b0;
        req_addr = 32'h0; req_size = 3'd0; req_wdata = 32'h0;
        bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", {31'h0, req_ready}, 32'd1);
        chk("rst_bus_valid", {31'h0, bus_valid}, 32'd0);
        chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_rsp_fault", {31'h0, rsp_fault}, 32'd0);
        chk("rst_bus_addr", bus_addr, 32'h0);
        chk("rst_bus_be", {28'h0, bus_be}, 32'h0);
        rst = 1'b0;

        // aligned LW
        access(1'b0, 1'b0, 32'h0000_0100, 3'd2, 32'h0, 0, 0);
        chk("lw_beats", nbeats, 1);
        chk("lw_addr", b_addr[0], 32'h0000_0100);
        chk("lw_be", {28'h0, b_be[0]}, 32'hF);
        chk("lw_rdata", r_rdata, 32'hDEAD_BEEF);
        chk("lw_fault", {31'h0, r_fault}, 32'd0);
        chk("lw_latency", rsp_cyc, 3);

        // byte loads from the top lane
        access(1'b0, 1'b0, 32'h0000_0203, 3'd0, 32'h0, 0, 0);
        chk("lb_be", {28'h0, b_be[0]}, 32'h8);
        chk("lb_addr", b_addr[0], 32'h0000_0200);
        chk("lb_rdata", r_rdata, 32'hFFFF_FF80);
        access(1'b0, 1'b0, 32'h0000_0203, 3'd4, 32'h0, 0, 0);
        chk("lbu_rdata", r_rdata, 32'h0000_0080);

        // split word store
        access(1'b0, 1'b1, 32'h0000_0301, 3'd2, 32'hAABB_CCDD, 0, 0);
        chk("sw_beats", nbeats, 2);
        chk("sw_b0_addr", b_addr[0], 32'h0000_0300);
        chk("sw_b0_be", {28'h0, b_be[0]}, 32'hE);
        chk("sw_b0_wd", {b_wd[0][31:8], 8'h00}, 32'hBBCC_DD00);
        chk("sw_b1_addr", b_addr[1], 32'h0000_0304);
        chk("sw_b1_be", {28'h0, b_be[1]}, 32'h1);
        chk("sw_b1_wd", {24'h0, b_wd[1][7:0]}, 32'h0000_00AA);
        chk("sw_latency", rsp_cyc, 3);
        chk("sw_rdata", r_rdata, 32'h0);

        // aligned byte store
        access(1'b0, 1'b1, 32'h0000_0401, 3'd0, 32'h0000_005A, 0, 0);
        chk("sb_be", {28'h0, b_be[0]}, 32'h2);
        chk("sb_wd", b_wd[0], 32'h0000_5A00);
        chk("sb_latency", rsp_cyc, 2);

        // split word load wrapping to address 0
        access(1'b0, 1'b0, 32'hFFFF_FFFE, 3'd2, 32'h0, 0, 0);
        chk("wrap_b0_addr", b_addr[0], 32'hFFFF_FFFC);
        chk("wrap_b1_addr", b_addr[1], 32'h0000_0000);
        chk("wrap_b0_be", {28'h0, b_be[0]}, 32'hC);
        chk("wrap_b1_be", {28'h0, b_be[1]}, 32'h3);
        chk("wrap_rdata", r_rdata, 32'h7788_1122);
        chk("wrap_latency", rsp_cyc, 5);

        // split halfword, signed and unsigned
        access(1'b0, 1'b0, 32'h0000_0203, 3'd1, 32'h0, 0, 0);
        chk("lh_split_beats", nbeats, 2);
        chk("lh_split_rdata", r_rdata, 32'hFFFF_C380);
        access(1'b0, 1'b0, 32'h0000_0203, 3'd5, 32'h0, 0, 0);
        chk("lhu_split_rdata", r_rdata, 32'h0000_C380);

        // stalled beat must hold steady
        access(1'b0, 1'b0, 32'h0000_0100, 3'd2, 32'h0, 2, 0);
        chk("stall_stable", unstable, 0);
        chk("stall_latency", rsp_cyc, 5);
        chk("stall_rdata", r_rdata, 32'hDEAD_BEEF);

        // illegal size: fault, no traffic, rdata cleared
        access(1'b0, 1'b0, 32'h0000_0100, 3'd3, 32'h0, 0, 0);
        chk("ill_bus_valid", nvalid, 0);
        chk("ill_fault", {31'h0, r_fault}, 32'd1);
        chk("ill_rdata", r_rdata, 32'h0);
        chk("ill_latency", rsp_cyc, 1);

        // no-split instance: aligned works, misaligned halfword faults
        access(1'b1, 1'b0, 32'h0000_0100, 3'd2, 32'h0, 0, 0);
        chk("ns_lw_rdata", r_rdata, 32'hDEAD_BEEF);
        access(1'b1, 1'b0, 32'h0000_0003, 3'd1, 32'h0, 0, 0);
        chk("ns_lh_bus_valid", nvalid, 0);
        chk("ns_lh_fault", {31'h0, r_fault}, 32'd1);
        chk("ns_lh_rdata", r_rdata, 32'h0);

        // reset while beat 1 of a split store is stalled
        sel = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0000_0301;
        req_size = 3'd2; req_wdata = 32'hAABB_CCDD;
        @(negedge clk);
        req_valid = 1'b0;
        bus_ready = 1'b1;
        @(negedge clk);
        bus_ready = 1'b0;
        chk("rstmid_b1_valid", {31'h0, bus_valid}, 32'd1);
        chk("rstmid_b1_addr", bus_addr, 32'h0000_0304);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_bus_valid", {31'h0, bus_valid}, 32'd0);
        chk("rstmid_req_ready", {31'h0, req_ready}, 32'd1);
        chk("rstmid_rsp_valid", {31'h0, rsp_valid}, 32'd0);
        rst = 1'b0;
        rsp_seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid || bus_valid) rsp_seen++;
        end
        chk("rstmid_quiet", rsp_seen, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
